// File: rtl/fp_alu_pkg.sv
`default_nettype none
// ============================================================================
// fp_alu_pkg : state encodings and byte-serial FP32 ALU protocol constants
// Revision   : 1.0
// ============================================================================
package fp_alu_pkg;

  typedef enum logic [3:0] {
    ST_FLUSH     = 4'd0,
    ST_IDLE      = 4'd1,
    ST_START     = 4'd2,
    ST_SEND      = 4'd3,
    ST_WAIT_DONE = 4'd4,
    ST_CAPTURE   = 4'd5,
    ST_RESP      = 4'd6
  } state_e;

  localparam int OPERAND_BYTES = 8;
  localparam int RESULT_BYTES  = 4;
  localparam int DONE_TO_DATA  = 1;
  localparam int ALU_MAX_TXN   = 14;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/alu_host_driver_if.sv
`default_nettype none
// ============================================================================
// alu_host_driver_if : request/response port plus ALU pin bundle
// Revision           : 1.0
// ============================================================================
interface alu_host_driver_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_timeout;
  logic [7:0]  alu_in;
  logic        alu_start;
  logic        alu_opcode;
  logic [7:0]  alu_out;
  logic        alu_done;
  logic [3:0]  state_out;

  modport master (
    input  req_valid, req_a, req_b, req_op, rsp_ready, alu_out, alu_done,
    output req_ready, rsp_valid, rsp_result, rsp_timeout,
           alu_in, alu_start, alu_opcode, state_out
  );

  modport slave (
    output req_valid, req_a, req_b, req_op, rsp_ready, alu_out, alu_done,
    input  req_ready, rsp_valid, rsp_result, rsp_timeout,
           alu_in, alu_start, alu_opcode, state_out
  );

endinterface
`default_nettype wire

// File: rtl/alu_host_driver.sv
`default_nettype none
// ============================================================================
// alu_host_driver : host-side master streaming operands to the byte-serial
//                   FP32 add/sub ALU and returning its 32-bit result
// Revision        : 1.0
// ============================================================================
module alu_host_driver
  import fp_alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int FLUSH_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_host_driver_if.master bus
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_e        state_q, state_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [2:0]    byte_cnt_q, byte_cnt_d;
  logic [63:0]   ops_q, ops_d;
  logic [7:0]    alu_in_q, alu_in_d;
  logic          alu_start_q, alu_start_d;
  logic          alu_opcode_q, alu_opcode_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_result_q, rsp_result_d;
  logic          rsp_timeout_q, rsp_timeout_d;

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    ops_d         = ops_q;
    alu_in_d      = alu_in_q;
    alu_start_d   = alu_start_q;
    alu_opcode_d  = alu_opcode_q;
    req_ready_d   = req_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      ST_FLUSH: begin
        if (flush_cnt_q == FW'(FLUSH_CYCLES - 1)) begin
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          ops_d        = {bus.req_b, bus.req_a};
          alu_opcode_d = bus.req_op;
          alu_start_d  = 1'b1;
          req_ready_d  = 1'b0;
          state_d      = ST_START;
        end
      end
      ST_START: begin
        alu_start_d = 1'b0;
        alu_in_d    = ops_q[7:0];
        ops_d       = {8'h00, ops_q[63:8]};
        byte_cnt_d  = 3'd0;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        byte_cnt_d = byte_cnt_q + 3'd1;
        if (byte_cnt_q == 3'(OPERAND_BYTES - 1)) begin
          alu_in_d  = 8'h00;
          tmo_cnt_d = '0;
          state_d   = ST_WAIT_DONE;
        end else begin
          alu_in_d = ops_q[7:0];
          ops_d    = {8'h00, ops_q[63:8]};
        end
      end
      ST_WAIT_DONE: begin
        if (bus.alu_done) begin
          byte_cnt_d = 3'd0;
          state_d    = ST_CAPTURE;
        end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rsp_result_d  = 32'h0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        // Result bytes arrive LSB first; shifting down lands byte 0 at [7:0].
        rsp_result_d = {bus.alu_out, rsp_result_q[31:8]};
        byte_cnt_d   = byte_cnt_q + 3'd1;
        if (byte_cnt_q == 3'(RESULT_BYTES - 1)) begin
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_timeout_d = 1'b0;
          alu_opcode_d  = OP_ADD;
          req_ready_d   = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: begin
        alu_in_d     = 8'h00;
        alu_start_d  = 1'b0;
        alu_opcode_d = OP_ADD;
        req_ready_d  = 1'b1;
        rsp_valid_d  = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_FLUSH;
      flush_cnt_q   <= '0;
      tmo_cnt_q     <= '0;
      byte_cnt_q    <= 3'd0;
      ops_q         <= 64'h0;
      alu_in_q      <= 8'h00;
      alu_start_q   <= 1'b0;
      alu_opcode_q  <= OP_ADD;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= 32'h0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      ops_q         <= ops_d;
      alu_in_q      <= alu_in_d;
      alu_start_q   <= alu_start_d;
      alu_opcode_q  <= alu_opcode_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.alu_in      = alu_in_q;
  assign bus.alu_start   = alu_start_q;
  assign bus.alu_opcode  = alu_opcode_q;
  assign bus.state_out   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_host_driver.sv
`default_nettype none
// ============================================================================
// tb_alu_host_driver : directed bench with a behavioural byte-serial FP32 ALU
// Revision           : 1.0
// ============================================================================
module tb_alu_host_driver;

  logic clk;
  logic rst_n;
  logic alu_clr;
  logic alu_mute;
  int   n_pass;
  int   n_total;

  alu_host_driver_if bus ();

  alu_host_driver #(
    .TIMEOUT_CYCLES (64),
    .FLUSH_CYCLES   (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FP32 <-> double conversions, valid for zero and normal numbers
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'h0) d = {f[31], 63'h0};
    else d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'h0) return {d[63], 31'h0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Behavioural ALU: start, 8 bytes in, execute, done, 4 bytes out one cycle behind done
  logic [1:0]  m_ph;
  logic [2:0]  m_cnt;
  logic [63:0] m_ops;
  logic [31:0] m_res;
  logic        m_op;

  always @(posedge clk) begin
    if (alu_clr) begin
      m_ph         <= 2'd0;
      m_cnt        <= 3'd0;
      m_ops        <= 64'h0;
      m_res        <= 32'h0;
      m_op         <= 1'b0;
      bus.alu_done <= 1'b0;
      bus.alu_out  <= 8'h00;
    end else begin
      case (m_ph)
        2'd0: if (bus.alu_start) begin m_ph <= 2'd1; m_cnt <= 3'd0; end
        2'd1: begin
          m_ops[{m_cnt, 3'b000} +: 8] <= bus.alu_in;
          m_cnt <= m_cnt + 3'd1;
          if (m_cnt == 3'd7) m_ph <= 2'd2;
        end
        2'd2: begin
          m_op  <= bus.alu_opcode;
          m_res <= bus.alu_opcode ? r2f(f2r(m_ops[31:0]) - f2r(m_ops[63:32]))
                                  : r2f(f2r(m_ops[31:0]) + f2r(m_ops[63:32]));
          bus.alu_done <= !alu_mute;
          m_cnt <= 3'd0;
          m_ph  <= 2'd3;
        end
        default: begin
          m_cnt <= m_cnt + 3'd1;
          if (m_cnt == 3'd4) begin
            bus.alu_out <= 8'h00;
            m_ph        <= 2'd0;
          end else begin
            bus.alu_out <= m_res[{m_cnt[1:0], 3'b000} +: 8];
            if (m_cnt == 3'd3) bus.alu_done <= 1'b0;
          end
        end
      endcase
    end
  end

  // Drives one request, waits for the response, holds rsp_ready low for 'hold' cycles
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input int hold, output logic [31:0] res, output logic tmo,
                         output int lat, output bit op_ok, output bit hold_ok,
                         output logic rdy_after);
    int guard;
    op_ok   = 1'b1;
    hold_ok = 1'b1;
    guard   = 0;
    @(negedge clk);
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    bus.req_valid = 1'b1;
    while (bus.req_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 200) begin
      if (bus.alu_opcode !== op) op_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    res = bus.rsp_result;
    tmo = bus.rsp_timeout;
    for (int i = 0; i < hold; i++) begin
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== res || bus.rsp_timeout !== tmo ||
          bus.req_ready !== 1'b0 || bus.alu_opcode !== op) hold_ok = 1'b0;
      @(negedge clk);
    end
    if (bus.alu_opcode !== op) op_ok = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    rdy_after = bus.req_ready;
  endtask

  task automatic test_reset;
    logic [52:0] obs;
    int n;
    rst_n = 1'b0;
    alu_clr = 1'b1;
    repeat (3) @(negedge clk);
    obs = {bus.alu_in, bus.alu_start, bus.alu_opcode, bus.req_ready, bus.rsp_valid,
           bus.rsp_timeout, bus.state_out, bus.rsp_result, 4'h0};
    n_total++;
    if (obs !== 53'h0) $display("FAIL reset_values: got %h, want 0", obs);
    else n_pass++;
    rst_n = 1'b1;
    alu_clr = 1'b0;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (n !== 16) $display("FAIL reset_flush_len: got %0d, want 16", n);
    else n_pass++;
    n_total++;
    if (bus.state_out !== 4'd1) $display("FAIL reset_idle_state: got %0d, want 1", bus.state_out);
    else n_pass++;
  endtask

  task automatic test_add;
    logic [31:0] res; logic tmo; int lat; bit op_ok, hold_ok; logic rdy;
    run_txn(32'h3F800000, 32'h40000000, 1'b0, 0, res, tmo, lat, op_ok, hold_ok, rdy);
    n_total++;
    if (m_ops !== 64'h40000000_3F800000) $display("FAIL add_bytes: got %h, want 400000003f800000", m_ops);
    else n_pass++;
    n_total++;
    if (res !== 32'h40400000) $display("FAIL add_result: got %h, want 40400000", res);
    else n_pass++;
    n_total++;
    if (tmo !== 1'b0) $display("FAIL add_timeout: got %b, want 0", tmo);
    else n_pass++;
    n_total++;
    if (lat !== 15) $display("FAIL add_latency: got %0d, want 15", lat);
    else n_pass++;
  endtask

  task automatic test_sub;
    logic [31:0] res; logic tmo; int lat; bit op_ok, hold_ok; logic rdy;
    run_txn(32'h40400000, 32'h3F800000, 1'b1, 0, res, tmo, lat, op_ok, hold_ok, rdy);
    n_total++;
    if (res !== 32'h40000000) $display("FAIL sub_result: got %h, want 40000000", res);
    else n_pass++;
    n_total++;
    if (op_ok !== 1'b1) $display("FAIL sub_opcode_stable: got %b, want 1", op_ok);
    else n_pass++;
    n_total++;
    if (m_op !== 1'b1) $display("FAIL sub_opcode_exec: got %b, want 1", m_op);
    else n_pass++;
    n_total++;
    if (bus.alu_opcode !== 1'b0) $display("FAIL sub_opcode_clear: got %b, want 0", bus.alu_opcode);
    else n_pass++;
  endtask

  task automatic test_timeout;
    logic [31:0] res; logic tmo; int lat; bit op_ok, hold_ok; logic rdy;
    alu_mute = 1'b1;
    run_txn(32'h3F800000, 32'h3F800000, 1'b0, 0, res, tmo, lat, op_ok, hold_ok, rdy);
    alu_mute = 1'b0;
    n_total++;
    if (lat !== 73) $display("FAIL timeout_latency: got %0d, want 73", lat);
    else n_pass++;
    n_total++;
    if (tmo !== 1'b1) $display("FAIL timeout_flag: got %b, want 1", tmo);
    else n_pass++;
    n_total++;
    if (res !== 32'h0) $display("FAIL timeout_result: got %h, want 0", res);
    else n_pass++;
    n_total++;
    if (bus.rsp_timeout !== 1'b0) $display("FAIL timeout_flag_clear: got %b, want 0", bus.rsp_timeout);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    logic [31:0] res; logic tmo; int lat; bit op_ok, hold_ok; logic rdy;
    run_txn(32'h40000000, 32'h3F800000, 1'b0, 5, res, tmo, lat, op_ok, hold_ok, rdy);
    n_total++;
    if (res !== 32'h40400000) $display("FAIL bp_result: got %h, want 40400000", res);
    else n_pass++;
    n_total++;
    if (hold_ok !== 1'b1) $display("FAIL bp_hold_stable: got %b, want 1", hold_ok);
    else n_pass++;
    n_total++;
    if (rdy !== 1'b1) $display("FAIL bp_ready_after: got %b, want 1", rdy);
    else n_pass++;
    n_total++;
    if (bus.rsp_valid !== 1'b0) $display("FAIL bp_valid_drop: got %b, want 0", bus.rsp_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_send;
    logic [31:0] res; logic tmo; int lat; bit op_ok, hold_ok; logic rdy;
    logic [52:0] obs;
    int guard, n;
    bit quiet;
    guard = 0;
    quiet = 1'b1;
    @(negedge clk);
    bus.req_a     = 32'h3F800000;
    bus.req_b     = 32'h40000000;
    bus.req_op    = 1'b1;
    bus.req_valid = 1'b1;
    while (bus.req_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    obs = {bus.alu_in, bus.alu_start, bus.alu_opcode, bus.req_ready, bus.rsp_valid,
           bus.rsp_timeout, bus.state_out, bus.rsp_result, 4'h0};
    n_total++;
    if (obs !== 53'h0) $display("FAIL midrst_values: got %h, want 0", obs);
    else n_pass++;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 40) begin
      if (bus.rsp_valid !== 1'b0 || bus.alu_start !== 1'b0) quiet = 1'b0;
      @(negedge clk);
      n++;
    end
    n_total++;
    if (n !== 16) $display("FAIL midrst_flush_len: got %0d, want 16", n);
    else n_pass++;
    n_total++;
    if (quiet !== 1'b1) $display("FAIL midrst_quiet: got %b, want 1", quiet);
    else n_pass++;
    run_txn(32'h3F800000, 32'h40000000, 1'b0, 0, res, tmo, lat, op_ok, hold_ok, rdy);
    n_total++;
    if (res !== 32'h40400000) $display("FAIL midrst_result: got %h, want 40400000", res);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int starts[$];
    logic [31:0] results[$];
    int cyc, gap;
    logic [31:0] r0, r1;
    cyc = 0;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    bus.req_a     = 32'h3F800000;
    bus.req_b     = 32'h40000000;
    bus.req_op    = 1'b0;
    bus.req_valid = 1'b1;
    while (results.size() < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.alu_start === 1'b1) begin
        starts.push_back(cyc);
        if (starts.size() == 1) begin
          bus.req_a  = 32'h40400000;
          bus.req_b  = 32'h3F800000;
          bus.req_op = 1'b1;
        end
      end
      if (bus.rsp_valid === 1'b1) results.push_back(bus.rsp_result);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    gap = (starts.size() >= 2) ? starts[1] - starts[0] : -1;
    r0  = (results.size() >= 1) ? results[0] : 32'hDEADBEEF;
    r1  = (results.size() >= 2) ? results[1] : 32'hDEADBEEF;
    n_total++;
    if (gap !== 17) $display("FAIL b2b_start_gap: got %0d, want 17", gap);
    else n_pass++;
    n_total++;
    if (r0 !== 32'h40400000) $display("FAIL b2b_result0: got %h, want 40400000", r0);
    else n_pass++;
    n_total++;
    if (r1 !== 32'h40000000) $display("FAIL b2b_result1: got %h, want 40000000", r1);
    else n_pass++;
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    alu_mute      = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a     = 32'h0;
    bus.req_b     = 32'h0;
    bus.req_op    = 1'b0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_timeout();
    test_backpressure();
    test_reset_mid_send();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/alu_host_driver.md
Name: alu_host_driver

Overview:
- Host-side master for the byte-serial FP32 add/sub ALU.
- Accepts a 32-bit operand pair plus opcode on a valid/ready request port, pulses the ALU start line, and streams the 8 operand bytes LSB-first (A0..A3, B0..B3).
- Waits for done, captures the 4 result bytes, and presents the 32-bit result on a valid/ready response port.
- Sits between the system bus adapter and the ALU pins.

Parameters:
- TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT_DONE before the driver aborts with rsp_timeout=1.
- FLUSH_CYCLES, 16, cycles req_ready is held low after reset, so any in-flight ALU transaction (14 cycles max) drains.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready; high only in IDLE.
- req_a  in  32  operand A (FP32).
- req_b  in  32  operand B (FP32).
- req_op  in  1  0=add, 1=subtract.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_result  out  32  captured result.
- rsp_timeout  out  1  1 = done never seen; rsp_result=0.
- alu_in  out  8  operand byte bus to ALU.
- alu_start  out  1  one-cycle start pulse.
- alu_opcode  out  1  opcode to ALU.
- alu_out  in  8  result byte bus from ALU.
- alu_done  in  1  ALU done.
- state_out  out  4  current FSM state (debug).

Behaviour:
- All outputs are registered.
- Reset values: alu_in=0, alu_start=0, alu_opcode=0, req_ready=0, rsp_valid=0, rsp_result=0, rsp_timeout=0; state=FLUSH, flush counter=0.
- FLUSH (0):
  - Count FLUSH_CYCLES; alu_done and alu_out are ignored.
  - Then go to IDLE with req_ready=1.
- IDLE (1):
  - On req_valid&req_ready: latch A, B and op; drive alu_opcode=op and alu_start=1; req_ready<=0; go to START.
- START (2):
  - alu_start is high for exactly this one cycle.
  - At the closing edge: alu_start<=0, alu_in<=A[7:0], byte counter=0, go to SEND.
- SEND (3):
  - The ALU samples alu_in at each edge in this state.
  - At the edge with count k: alu_in<=byte k+1 of the {B,A} sequence.
  - After count 7: alu_in<=0, timeout counter=0, go to WAIT_DONE.
- WAIT_DONE (4):
  - On the first edge sampling alu_done=1: go to CAPTURE, count=0.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 without done: rsp_result<=0, rsp_timeout<=1, rsp_valid<=1, go to RESP.
- CAPTURE (5):
  - alu_out lags done by one cycle, so the first capture edge is one cycle after the done-detect edge.
  - Capture alu_out into rsp_result[8k+7:8k] for k=0..3 on 4 consecutive edges.
  - alu_done is not checked here; it falls during capture.
  - After k=3: rsp_valid<=1, rsp_timeout<=0, go to RESP.
- RESP (6):
  - Hold rsp_* stable until rsp_ready.
  - On the handshake edge: rsp_valid<=0, rsp_timeout<=0, alu_opcode<=0, req_ready<=1, go to IDLE.
  - A new request is accepted no earlier than the cycle after the response handshake.
- alu_opcode is held constant from START through RESP, since the ALU uses it combinationally at its execute cycle.
- Latency: with the request accepted at edge T, rsp_valid rises after edge T+15 for a conforming ALU.
- Undefined state encodings go to IDLE with all ALU outputs at 0.
- Reset mid-transaction: return to FLUSH. The ALU may still complete, but its done pulse and result are discarded.
- rsp_ready held high does not skip RESP; the minimum RESP occupancy is 1 cycle.

Decomposition:
- Shared package fp_alu_pkg holds:
  - state encodings (FLUSH..RESP);
  - ALU protocol constants: OPERAND_BYTES=8, RESULT_BYTES=4, DONE_TO_DATA=1, ALU_MAX_TXN=14;
  - opcode constants OP_ADD=0, OP_SUB=1.
- No sub-module. The FSM, 3-bit byte counter, timeout counter and flush counter stay flat in one module.

Test Plan:
1. Add: A=0x3F800000 (1.0), B=0x40000000 (2.0), op=0, paired with the real ALU.
   - alu_in sequence is 00,00,80,3F,00,00,00,40 on the 8 SEND edges.
   - rsp_result=0x40400000 and rsp_timeout=0; rsp_valid rises exactly 15 cycles after accept.
2. Subtract: A=0x40400000, B=0x3F800000, op=1.
   - rsp_result=0x40000000.
   - alu_opcode is stable at 1 from START through RESP.
3. Timeout: stub ALU never asserts done, TIMEOUT_CYCLES=64.
   - rsp_valid rises 64 cycles after entering WAIT_DONE, with rsp_timeout=1 and rsp_result=0.
4. Backpressure: rsp_ready low for 5 cycles after rsp_valid.
   - rsp_* are held stable; req_ready stays 0 until the handshake and is 1 on the next cycle.
5. Reset during SEND, after byte 3 (rst_n low for 1 cycle).
   - All outputs return to their reset values and req_ready is 0 for 16 cycles.
   - A subsequent 1.0+2.0 request returns 0x40400000.
6. Back-to-back: two requests with req_valid held high and rsp_ready tied high.
   - alu_start pulses are 17 cycles apart and both results are correct.
